mem_arb: RTL
============

# mem_arb

Two-port arbiter that shares the single CPU memory bus between the instruction-fetch unit and the memory/writeback stage. It accepts level-held requests from both requesters and forwards one transaction at a time to the bus. The one-cycle acknowledge and read data go back to the granted requester only. It sits between the pipeline front/back ends and the external memory interface, and adds a bus timeout that terminates hung transactions with an error pulse.

## Interface
- `W`, 16: data and address width (matches `` `RW``).
- `TO_CYC`, 255: timeout in cycles counted from bus request assertion; 0 disables the timeout.
- `i_clk` in 1: clock, all state updates on rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_d_req` in 1: data-port (memwb) request, level.
- `i_d_we` in 1: data-port write enable.
- `i_d_addr` in W: data-port address.
- `i_d_wdata` in W: data-port write data.
- `o_d_ack` out 1: data-port acknowledge, one-cycle pulse.
- `i_f_req` in 1: fetch-port request, level.
- `i_f_addr` in W: fetch-port address; fetch is always read.
- `o_f_ack` out 1: fetch-port acknowledge, one-cycle pulse.
- `o_rdata` out W: read data, shared by both ports, valid only in the ack cycle.
- `o_err` out 1: pulses together with the ack when a transaction is terminated by timeout.
- `o_mem_req` out 1: bus request, level.
- `o_mem_we` out 1: bus write enable.
- `o_mem_addr` out W: bus address.
- `o_mem_data` out W: bus write data.
- `i_mem_ack` in 1: bus acknowledge, one-cycle pulse.
- `i_mem_data` in W: bus read data.

## Operation
- **Requester contract**
  - A requester raises req and holds req, we, addr and wdata stable until it sees its ack.
  - The requester may drop req, or present a new request, in the cycle after its ack.
- **State machine**, two states: IDLE and BUSY.
- **IDLE, arbitration**
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not granted last (round-robin via a `last` register).
  - On a grant: latch `gnt`, set `o_mem_req` = 1, clear the timeout counter, go to BUSY.
- **Bus muxing**
  - In BUSY, addr, we and data are driven combinationally from the granted port's inputs.
  - A fetch grant forces `o_mem_we` = 0 and `o_mem_data` = 0.
  - In IDLE, all bus outputs are 0.
- **BUSY**
  - On `i_mem_ack`: pulse the granted port's ack in the same cycle, with `o_rdata` = `i_mem_data` and `o_err` = 0.
  - At that clock edge: set `o_mem_req` to 0, update `last` to `gnt`, go to IDLE.
  - Each cycle without ack, the timeout counter increments, saturating.
  - When the counter equals `TO_CYC`-1 with no ack (`TO_CYC` != 0): pulse the granted ack with `o_err` = 1 and `o_rdata` = 0. Then drop `o_mem_req`, update `last`, go to IDLE.
  - An ack arriving in the same cycle as the timeout wins: it is a normal completion and `o_err` = 0.
- **Ack gating**
  - Acks are gated by BUSY and `gnt`.
  - A stray `i_mem_ack` in IDLE is ignored: no port ack, no state change.
- **Request sampling**
  - A request dropped before its grant is simply not seen.
  - Requests are never cancelled once granted; a requester dropping req in BUSY does not abort the bus cycle.
- **Reset values:** state IDLE, `o_mem_req` 0, `last` = fetch (so data wins the first tie), counter 0, `o_d_ack`/`o_f_ack`/`o_err` 0, `o_rdata` 0, bus outputs 0.
- **Reset mid-transaction:** `o_mem_req` drops on the next edge. A pending ack is discarded and the requester receives no ack.

## Timing
- **Grant latency:** a req high at edge N (sampled in IDLE) produces `o_mem_req` high in cycle N+1.
- **Ack path:** combinational from `i_mem_ack` to the port ack, zero added latency.
- **Back-to-back:** ack in cycle T, IDLE in T+1 re-arbitrates, next `o_mem_req` in T+2. Minimum bus turnaround is one idle cycle.
- **Fairness:** with both ports continuously requesting, grants alternate D, F, D, F...
- **Counter width:** `$clog2(TO_CYC+1)` bits, saturating. Timeout fires on the `TO_CYC`-th BUSY cycle.

## Test plan
- **Single read:** after reset, `i_f_req`=1 with addr 0x0040; memory acks 3 cycles after `o_mem_req` with 0xBEEF → `o_mem_req` rises 1 cycle after req, `o_mem_we`=0, `o_f_ack` and `o_rdata`=0xBEEF for one cycle, `o_d_ack` stays 0.
- **Tie and round-robin:** both req held with `d_addr`=0x1000 (write 0x55AA) and `f_addr`=0x2000, ack each after 1 cycle → bus sequence 0x1000 (we=1, data 0x55AA), 0x2000, 0x1000, 0x2000, with one idle cycle between transactions.
- **Timeout:** `TO_CYC`=4, data read never acked → `o_d_ack`=1 with `o_err`=1 and `o_rdata`=0 on the 4th BUSY cycle, `o_mem_req` low on the next cycle. A late `i_mem_ack` is ignored.
- **Ack/timeout collision:** `TO_CYC`=4, ack in the 4th BUSY cycle → normal ack, `o_err`=0.
- **Stray ack:** `i_mem_ack` pulsed in IDLE → no port ack, `o_mem_req` stays 0.
- **Reset mid-transfer:** `i_rst` during BUSY → `o_mem_req`=0 next cycle. A subsequent tie goes to the data port first.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port memory bus arbiter: round-robin between the data (memwb) port and the
// fetch port, one bus transaction at a time, with a bus timeout that ends hung cycles.
module mem_arb #(
  parameter int W      = 16,
  parameter int TO_CYC = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_d_req,
  input  logic         i_d_we,
  input  logic [W-1:0] i_d_addr,
  input  logic [W-1:0] i_d_wdata,
  output logic         o_d_ack,
  input  logic         i_f_req,
  input  logic [W-1:0] i_f_addr,
  output logic         o_f_ack,
  output logic [W-1:0] o_rdata,
  output logic         o_err,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [W-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_data,
  input  logic         i_mem_ack,
  input  logic [W-1:0] i_mem_data
);

  localparam int         CW      = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam bit         TO_EN   = (TO_CYC != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? TO_CYC - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic          gnt_d;   // 1: data port owns the bus, 0: fetch port
  logic          last_d;  // port that completed most recently
  logic          mem_req_q;
  logic [CW-1:0] cnt;

  logic busy, live, to_hit, fin;

  assign busy   = (state == BUSY);
  // A transaction being reset must not hand an ack back to its requester.
  assign live   = busy && !i_rst;
  assign to_hit = TO_EN && (cnt == TO_LAST);
  assign fin    = live && (i_mem_ack || to_hit);

  assign o_d_ack   = fin && gnt_d;
  assign o_f_ack   = fin && !gnt_d;
  assign o_err     = fin && !i_mem_ack;
  assign o_rdata   = (live && i_mem_ack) ? i_mem_data : '0;

  assign o_mem_req  = mem_req_q;
  assign o_mem_we   = busy && gnt_d && i_d_we;
  assign o_mem_addr = !busy ? '0 : (gnt_d ? i_d_addr : i_f_addr);
  assign o_mem_data = (busy && gnt_d) ? i_d_wdata : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      gnt_d     <= 1'b0;
      last_d    <= 1'b0;
      mem_req_q <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_d_req || i_f_req) begin
            gnt_d     <= i_d_req && (!i_f_req || !last_d);
            mem_req_q <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (i_mem_ack || to_hit) begin
            mem_req_q <= 1'b0;
            last_d    <= gnt_d;
            state     <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
